// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, bias and the arbiter FSM encodings.
package fp32_pkg;
    localparam int FP32_BIAS   = 127;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } fsmStateT;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } mulOpT;
endpackage

// File: rtl/fp32_mul_core.sv
// Combinational fp32 multiply: truncating, zero-flush only, exponent wraps mod 256.
module fp32_mul_core
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    localparam int SIG_W = FP32_MANT_W + 1;
    localparam int EXP_HI = FP32_EXP_W + FP32_MANT_W - 1;

    logic                   signBit;
    logic [SIG_W-1:0]       sigA, sigB;
    logic [2*SIG_W-1:0]     prodSig;
    logic [FP32_EXP_W+1:0]  expSum;
    logic [FP32_MANT_W-1:0] mant;
    logic                   isZero;

    always_comb begin
        signBit = a[31] ^ b[31];
        sigA    = {1'b1, a[FP32_MANT_W-1:0]};
        sigB    = {1'b1, b[FP32_MANT_W-1:0]};
        prodSig = (2*SIG_W)'(sigA) * (2*SIG_W)'(sigB);
        // Two guard bits keep the bias subtraction from borrowing out; low 8 bits are the wrapped exponent.
        expSum  = {2'b00, a[EXP_HI:FP32_MANT_W]} + {2'b00, b[EXP_HI:FP32_MANT_W]}
                + {{(FP32_EXP_W+1){1'b0}}, prodSig[2*SIG_W-1]} - (FP32_EXP_W+2)'(FP32_BIAS);
        mant    = prodSig[2*SIG_W-1] ? prodSig[2*SIG_W-2:SIG_W] : prodSig[2*SIG_W-3:SIG_W-1];
        isZero  = (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
        product = isZero ? {signBit, 31'd0} : {signBit, expSum[FP32_EXP_W-1:0], mant};
    end
endmodule

// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one fp32 multiply core among NREQ requesters,
// with a registered product stage and a valid/ready response channel.
module fp32_mul_arbiter
    import fp32_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_product,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);
    fsmStateT       state;
    mulOpT          opReg;
    logic [IDW-1:0] lastGrant;
    logic [IDW-1:0] gntId;
    logic [IDW-1:0] winId;
    logic           anyValid;
    logic [31:0]    coreProduct;

    fp32_mul_core uCore (
        .a       (opReg.a),
        .b       (opReg.b),
        .product (coreProduct)
    );

    // Walk the search order backwards so the nearest requester after lastGrant is the last write.
    always_comb begin
        int idx;
        anyValid = |req_valid;
        winId    = '0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(lastGrant) + k) % NREQ;
            if (req_valid[IDW'(idx)]) winId = IDW'(idx);
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && anyValid) req_ready[winId] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lastGrant   <= IDW'(NREQ - 1);
            gntId       <= '0;
            opReg       <= '0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (anyValid) begin
                        opReg <= '{a: req_a[winId], b: req_b[winId]};
                        gntId <= winId;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    rsp_product <= coreProduct;
                    rsp_id      <= gntId;
                    rsp_valid   <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        lastGrant <= gntId;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Scoreboard bench for fp32_mul_arbiter: inputs change on the falling edge,
// outputs are sampled 1ns later.
module tb_fp32_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a = '0;
    logic [NREQ-1:0][31:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [31:0]           rsp_product;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    fp32_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    prod;
    } expT;

    expT sb[$];
    int  vecs = 0;
    int  errs = 0;

    localparam logic [31:0] VA [5] = '{32'h3FC00000, 32'hC0000000, 32'h00000000, 32'h80000000, 32'h3FAAAAAB};
    localparam logic [31:0] VB [5] = '{32'h3FC00000, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40400000};
    localparam logic [31:0] VP [5] = '{32'h40100000, 32'hC0C00000, 32'h00000000, 32'h80000000, 32'h40800000};
    localparam int          RR_EXP [5] = '{0, 1, 2, 3, 0};

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if ({rsp_valid, busy, req_ready} !== '0) begin
            errs++;
            $display("FAIL reset_ctrl got valid=%b busy=%b ready=%b exp 0/0/0", rsp_valid, busy, req_ready);
        end
        vecs++;
        if (rsp_product !== 32'h0 || rsp_id !== '0) begin
            errs++;
            $display("FAIL reset_data got %h/%0d exp 00000000/0", rsp_product, rsp_id);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        expT e;
        @(negedge clk);
        rsp_ready = 1'b1; req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_valid = 4'b0001;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++; $display("FAIL basic_ready got %b exp 0001", req_ready);
        end else sb.push_back('{2'd0, 32'h40C00000});
        @(negedge clk); req_valid = '0; #1;
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL basic_t1 got valid=%b busy=%b exp 0/1", rsp_valid, busy);
        end
        @(negedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b1) begin
            errs++; $display("FAIL basic_latency got valid=%b exp 1 at accept+2", rsp_valid);
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            vecs++;
            if (rsp_product !== e.prod || rsp_id !== e.id) begin
                errs++; $display("FAIL basic_rsp got %h/%0d exp %h/%0d", rsp_product, rsp_id, e.prod, e.id);
            end
        end
        @(negedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL basic_done got valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_products();
        expT e;
        bit  got;
        for (int v = 0; v < 5; v++) begin
            int rq = v % NREQ;
            @(negedge clk);
            rsp_ready = 1'b1; req_a[rq] = VA[v]; req_b[rq] = VB[v]; req_valid = NREQ'(1) << rq;
            #1;
            vecs++;
            if (req_ready !== (NREQ'(1) << rq)) begin
                errs++; $display("FAIL prod_accept[%0d] got %b", v, req_ready);
            end else sb.push_back('{IDW'(rq), VP[v]});
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk); req_valid = '0; #1;
                if (rsp_valid) begin
                    got = 1;
                    if (sb.size() == 0) begin
                        vecs++; errs++; $display("FAIL prod_unexpected id=%0d", rsp_id);
                    end else begin
                        e = sb.pop_front();
                        vecs++;
                        if (rsp_product !== e.prod || rsp_id !== e.id) begin
                            errs++;
                            $display("FAIL prod[%0d] %h*%h got %h/%0d exp %h/%0d", v, VA[v], VB[v],
                                     rsp_product, rsp_id, e.prod, e.id);
                        end
                    end
                end
            end
            if (!got) begin
                vecs++; errs++; $display("FAIL prod_timeout[%0d] no rsp_valid", v);
            end
        end
    endtask

    task automatic test_round_robin();
        expT             e;
        int              order[$];
        logic [NREQ-1:0] prevReady = '0;
        @(negedge clk); rst_n = 1'b0; req_valid = '0;
        @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 32'h3F800000;
            req_b[i] = 32'h40000000 + 32'(i << 20);
        end
        req_valid = '1;
        #1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            vecs++;
            if (!$onehot0(req_ready) || (prevReady & req_ready) != '0) begin
                errs++; $display("FAIL rr_pulse cycle %0d got %b prev %b", c, req_ready, prevReady);
            end
            prevReady = req_ready;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin
                    order.push_back(i);
                    sb.push_back('{IDW'(i), req_b[i]});
                end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    vecs++; errs++; $display("FAIL rr_unexpected id=%0d", rsp_id);
                end else begin
                    e = sb.pop_front();
                    vecs++;
                    if (rsp_product !== e.prod || rsp_id !== e.id) begin
                        errs++; $display("FAIL rr_rsp got %h/%0d exp %h/%0d", rsp_product, rsp_id, e.prod, e.id);
                    end
                end
            end
        end
        @(negedge clk); req_valid = '0;
        vecs++;
        if (order.size() != 5) begin
            errs++; $display("FAIL rr_count got %0d grants exp 5", order.size());
        end
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            vecs++;
            if (order[k] != RR_EXP[k]) begin
                errs++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], RR_EXP[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        expT            e;
        bit             got;
        logic [31:0]    capP;
        logic [IDW-1:0] capId;
        // Last grant was requester 0, so 1 wins now and 2 right after.
        @(negedge clk); rsp_ready = 1'b0; req_valid = '1; #1;
        vecs++;
        if (req_ready !== 4'b0010) begin
            errs++; $display("FAIL bp_grant got %b exp 0010", req_ready);
        end
        sb.push_back('{2'd1, req_b[1]});
        got = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk); #1;
            got = rsp_valid;
        end
        if (!got) begin
            vecs++; errs++; $display("FAIL bp_timeout no rsp_valid");
        end
        capP = rsp_product; capId = rsp_id;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_product !== capP || rsp_id !== capId || req_ready !== '0) begin
                errs++;
                $display("FAIL bp_hold cycle %0d got v=%b %h/%0d rdy=%b exp 1 %h/%0d 0000",
                         c, rsp_valid, rsp_product, rsp_id, req_ready, capP, capId);
            end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        e = sb.pop_front();
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_product !== e.prod || rsp_id !== e.id) begin
            errs++; $display("FAIL bp_rsp got v=%b %h/%0d exp 1 %h/%0d", rsp_valid, rsp_product, rsp_id, e.prod, e.id);
        end
        @(negedge clk); #1;
        vecs++;
        if (req_ready !== 4'b0100) begin
            errs++; $display("FAIL bp_next_grant got %b exp 0100", req_ready);
        end else sb.push_back('{2'd2, req_b[2]});
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (rsp_valid && sb.size() != 0) begin
                got = 1;
                e = sb.pop_front();
                vecs++;
                if (rsp_product !== e.prod || rsp_id !== e.id) begin
                    errs++; $display("FAIL bp_drain got %h/%0d exp %h/%0d", rsp_product, rsp_id, e.prod, e.id);
                end
            end
        end
        if (!got) begin
            vecs++; errs++; $display("FAIL bp_drain_timeout");
        end
    endtask

    task automatic test_reset_mid_op();
        expT e;
        bit  got;
        @(negedge clk); rsp_ready = 1'b1; req_valid = 4'b0010; #1;
        vecs++;
        if (req_ready !== 4'b0010) begin
            errs++; $display("FAIL rmid_grant got %b exp 0010", req_ready);
        end
        @(negedge clk); req_valid = '0; rst_n = 1'b0; #1;
        vecs++;
        if (busy !== 1'b1) begin
            errs++; $display("FAIL rmid_in_mul got busy=%b exp 1", busy);
        end
        @(negedge clk); rst_n = 1'b1; req_valid = '1; #1;
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL rmid_flush got valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++; $display("FAIL rmid_regrant got %b exp 0001", req_ready);
        end else sb.push_back('{2'd0, req_b[0]});
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (rsp_valid && sb.size() != 0) begin
                got = 1;
                e = sb.pop_front();
                vecs++;
                if (rsp_product !== e.prod || rsp_id !== e.id) begin
                    errs++; $display("FAIL rmid_rsp got %h/%0d exp %h/%0d", rsp_product, rsp_id, e.prod, e.id);
                end
            end
        end
        if (!got) begin
            vecs++; errs++; $display("FAIL rmid_timeout");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        @(negedge clk);
        vecs++;
        if (sb.size() != 0) begin
            errs++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
